// File: rtl/hamming_nibble_assembler.sv
// Hamming nibble assembler: pairs corrected nibbles from an eH(8,4) decoder
// into bytes, carries per-byte error flags, and keeps saturating error/byte
// statistics.
module hamming_nibble_assembler #(
   parameter bit          LOW_FIRST = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   input  logic             in_corr,
   input  logic             in_uncorr,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_byte,
   output logic             out_fixed,
   output logic             out_bad,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt,
   output logic [CNT_W-1:0] byte_cnt
);

   typedef enum logic [1:0] {
      ST_FIRST  = 2'd0,
      ST_SECOND = 2'd1,
      ST_FULL   = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [3:0]       nib_q, nib_d;
   logic             nib_fixed_q, nib_fixed_d;
   logic             nib_bad_q, nib_bad_d;
   logic [7:0]       byte_q, byte_d;
   logic             fixed_q, fixed_d;
   logic             bad_q, bad_d;
   logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

   logic accept;
   logic out_hs;
   logic cls_bad;
   logic cls_fixed;

   // Handshakes and nibble classification (uncorrectable dominates corrected)
   always_comb begin
      in_ready  = (state_q == ST_FULL) ? out_ready : 1'b1;
      accept    = in_valid & in_ready;
      out_hs    = (state_q == ST_FULL) & out_ready;
      cls_bad   = in_uncorr;
      cls_fixed = in_corr & ~in_uncorr;
   end

   // Next-state and datapath: collect two nibbles, hold byte until consumed
   always_comb begin
      state_d     = state_q;
      nib_d       = nib_q;
      nib_fixed_d = nib_fixed_q;
      nib_bad_d   = nib_bad_q;
      byte_d      = byte_q;
      fixed_d     = fixed_q;
      bad_d       = bad_q;
      unique case (state_q)
         ST_FIRST: begin
            if (accept) begin
               nib_d       = in_data;
               nib_fixed_d = cls_fixed;
               nib_bad_d   = cls_bad;
               state_d     = ST_SECOND;
            end
         end
         ST_SECOND: begin
            if (accept) begin
               byte_d  = LOW_FIRST ? {in_data, nib_q} : {nib_q, in_data};
               fixed_d = nib_fixed_q | cls_fixed;
               bad_d   = nib_bad_q | cls_bad;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // An accept here implies out_ready, so it always rides on a handshake
            if (out_hs) begin
               if (accept) begin
                  nib_d       = in_data;
                  nib_fixed_d = cls_fixed;
                  nib_bad_d   = cls_bad;
                  state_d     = ST_SECOND;
               end else begin
                  state_d = ST_FIRST;
               end
            end
         end
         default: state_d = ST_FIRST;
      endcase
   end

   // Saturating statistics; clear wins over any same-cycle increment
   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      if (clr_stats) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
         byte_cnt_d   = '0;
      end else begin
         if (accept && cls_fixed && (corr_cnt_q != CNT_MAX)) begin
            corr_cnt_d = corr_cnt_q + CNT_ONE;
         end
         if (accept && cls_bad && (uncorr_cnt_q != CNT_MAX)) begin
            uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
         end
         if (out_hs && (byte_cnt_q != CNT_MAX)) begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
         end
      end
   end

   // State and data registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FIRST;
         nib_q        <= 4'h0;
         nib_fixed_q  <= 1'b0;
         nib_bad_q    <= 1'b0;
         byte_q       <= 8'h00;
         fixed_q      <= 1'b0;
         bad_q        <= 1'b0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
         byte_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         nib_q        <= nib_d;
         nib_fixed_q  <= nib_fixed_d;
         nib_bad_q    <= nib_bad_d;
         byte_q       <= byte_d;
         fixed_q      <= fixed_d;
         bad_q        <= bad_d;
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
      end
   end

   assign out_valid  = (state_q == ST_FULL);
   assign out_byte   = byte_q;
   assign out_fixed  = fixed_q;
   assign out_bad    = bad_q;
   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;
   assign byte_cnt   = byte_cnt_q;

endmodule
